// File: rtl/uart_pkg.sv
// Shared UART definitions: default frame parameters and FSM state encodings.
// Defining UART_TX_PARITY_EN widens the state type to make room for the PARITY state.
package uart_pkg;

  localparam int unsigned DefaultClocksPerPulse = 16;
  localparam int unsigned DefaultDataWidth      = 8;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    StIdle   = 3'b000,
    StStart  = 3'b001,
    StData   = 3'b011,
    StStop   = 3'b010,
    StParity = 3'b100
  } uart_state_e;
`else
  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StStart = 2'b01,
    StData  = 2'b11,
    StStop  = 2'b10
  } uart_state_e;
`endif

endpackage

// File: rtl/uart_bit_timer.sv
// Per-bit clock counter: counts CLOCKS_PER_PULSE cycles per serial bit while enabled.
// bit_end marks the last cycle of a bit; bit_pre_end marks the cycle before it.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_PULSE = DefaultClocksPerPulse
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic enable,
  output logic bit_pre_end,
  output logic bit_end
);

  localparam int unsigned CntW = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(CLOCKS_PER_PULSE - 1);
  localparam logic [CntW-1:0] PreCnt  = CntW'(CLOCKS_PER_PULSE - 2);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign bit_end     = enable && (cnt_q == LastCnt);
  assign bit_pre_end = enable && (cnt_q == PreCnt);

  always_comb begin
    cnt_d = cnt_q;
    if (clear || bit_end) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH bits LSB first, stop bit; all outputs registered.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_PULSE = DefaultClocksPerPulse,
  parameter int unsigned DATA_WIDTH       = DefaultDataWidth
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned BitCntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_WIDTH - 1);

  uart_state_e           state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [BitCntW-1:0]    bit_cnt_q;
  logic                  tx_q, busy_q, done_q, ready_q;
`ifdef UART_TX_PARITY_EN
  logic                  parity_q;
`endif
  logic                  accept, bit_pre_end, bit_end;

  assign accept = ready_q && data_valid;

  // Acceptance realigns the counter so the start bit gets a full CLOCKS_PER_PULSE cycles.
  uart_bit_timer #(
    .CLOCKS_PER_PULSE(CLOCKS_PER_PULSE)
  ) u_bit_timer (
    .clk        (clk),
    .rstn       (rstn),
    .clear      (accept),
    .enable     (state_q != StIdle),
    .bit_pre_end(bit_pre_end),
    .bit_end    (bit_end)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          tx_q <= 1'b1;
          if (accept) begin
            state_q  <= StStart;
            shift_q  <= data_in;
            tx_q     <= 1'b0;
            busy_q   <= 1'b1;
            ready_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= ^data_in;
`endif
          end else begin
            ready_q <= 1'b1;
          end
        end
        StStart: begin
          if (bit_end) begin
            state_q   <= StData;
            tx_q      <= shift_q[0];
            shift_q   <= shift_q >> 1;
            bit_cnt_q <= '0;
          end
        end
        StData: begin
          if (bit_end) begin
            if (bit_cnt_q == LastBit) begin
`ifdef UART_TX_PARITY_EN
              state_q <= StParity;
              tx_q    <= parity_q;
`else
              state_q <= StStop;
              tx_q    <= 1'b1;
`endif
            end else begin
              tx_q      <= shift_q[0];
              shift_q   <= shift_q >> 1;
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        StParity: begin
          if (bit_end) begin
            state_q <= StStop;
            tx_q    <= 1'b1;
          end
        end
`endif
        StStop: begin
          // Raised one cycle early so the registered pulse lands on the last stop cycle.
          if (bit_pre_end) done_q <= 1'b1;
          if (bit_end) begin
            state_q <= StIdle;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign data_ready = ready_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
